// File: rtl/int_dispatch_queue_pkg.sv
// -----------------------------------------------------------------------------
// int_dispatch_queue_pkg
//   Shared definitions for the integer dispatch queue: ROB index width, ALU
//   issue width, the integer issue payload bundle and the ROB age comparator.
//   A ROB index is {wrap, idx}; the MSB is the wrap bit.
// -----------------------------------------------------------------------------
package int_dispatch_queue_pkg;

   localparam int ROB_WIDTH = 6;   // 5 index bits + 1 wrap bit
   localparam int ALU_SIZE  = 4;   // integer ALUs fed per cycle

   typedef struct packed {
      logic [7:0] opcode;
      logic [5:0] rd;
      logic [5:0] rs1;
      logic [5:0] rs2;
      logic [5:0] tag;
   } IntIssueBundle;

   // Returns 1 when ROB index a is younger than ROB index b.
   function automatic logic LoopCompare(input logic [ROB_WIDTH-1:0] a,
                                        input logic [ROB_WIDTH-1:0] b);
      logic same_wrap;
      same_wrap = (a[ROB_WIDTH-1] == b[ROB_WIDTH-1]);
      return same_wrap ? (a[ROB_WIDTH-2:0] > b[ROB_WIDTH-2:0])
                       : (a[ROB_WIDTH-2:0] < b[ROB_WIDTH-2:0]);
   endfunction

endpackage

// File: rtl/int_dispatch_queue_popcount.sv
// -----------------------------------------------------------------------------
// dq_popcount
//   Counts the set bits of a vector. Used for enqueue, dequeue and redirect
//   survivor counts inside the dispatch queue.
//   Ports: i_vec  - input vector
//          o_cnt  - number of set bits in i_vec
// -----------------------------------------------------------------------------
module dq_popcount #(
   parameter int WIDTH = 4,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic [WIDTH-1:0] i_vec,
   output logic [CNT_W-1:0] o_cnt
);

   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      o_cnt = '0;
      for (int i = 0; i < WIDTH; i++) begin
         o_cnt = o_cnt + CNT_W'(i_vec[i]);
      end
   end

endmodule

// File: rtl/int_dispatch_queue.sv
// -----------------------------------------------------------------------------
// int_dispatch_queue
//   Circular FIFO between rename and the integer issue queue. Up to IN_WIDTH
//   entries enqueue per cycle; up to OUT_WIDTH oldest entries are presented
//   every cycle and are consumed whenever presented (out_en is the handshake).
//   A redirect drops every entry strictly younger than redirect_idx.
//   Ports: clk, rst (async, active low)
//          in_en/in_data/in_rob_idx - enqueue slots, valid bits contiguous
//          in_ready                 - room for a full IN_WIDTH group
//          out_en/out_data/out_rob_idx - dequeue slots, slot 0 oldest
//          issue_full               - suppresses dequeue
//          redirect/redirect_idx    - flush of younger entries
//          count                    - registered occupancy
// -----------------------------------------------------------------------------
module int_dispatch_queue
   import int_dispatch_queue_pkg::*;
#(
   parameter int DEPTH      = 16,
   parameter int IN_WIDTH   = 4,
   parameter int OUT_WIDTH  = ALU_SIZE,
   parameter int DATA_WIDTH = $bits(IntIssueBundle)
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [IN_WIDTH-1:0]             in_en,
   input  logic [IN_WIDTH*DATA_WIDTH-1:0]  in_data,
   input  logic [IN_WIDTH*ROB_WIDTH-1:0]   in_rob_idx,
   output logic                            in_ready,
   output logic [OUT_WIDTH-1:0]            out_en,
   output logic [OUT_WIDTH*DATA_WIDTH-1:0] out_data,
   output logic [OUT_WIDTH*ROB_WIDTH-1:0]  out_rob_idx,
   input  logic                            issue_full,
   input  logic                            redirect,
   input  logic [ROB_WIDTH-1:0]            redirect_idx,
   output logic [$clog2(DEPTH):0]          count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CW    = PTR_W + 1;
   localparam int ENQ_W = $clog2(IN_WIDTH + 1);
   localparam int DEQ_W = $clog2(OUT_WIDTH + 1);

   // Pointers carry a wrap bit above the index: equal index with different
   // wrap bits means full.
   logic [PTR_W:0]          r_head;
   logic [PTR_W:0]          r_tail;
   logic [CW-1:0]           r_count;
   logic [DATA_WIDTH-1:0]   r_data [DEPTH];
   logic [ROB_WIDTH-1:0]    r_rob  [DEPTH];

   logic [IN_WIDTH-1:0]     w_enq_mask;
   logic [ENQ_W-1:0]        w_enq_cnt;
   logic [DEQ_W-1:0]        w_deq_cnt;
   logic [DEPTH-1:0]        w_alive;
   logic [CW-1:0]           w_alive_cnt;

   function automatic logic [PTR_W-1:0] slot(input logic [PTR_W-1:0] base,
                                             input int               off);
      return base + PTR_W'(off);
   endfunction

   // Readiness uses the registered count only; a same-cycle dequeue is not
   // credited, which keeps in_ready off the issue_full path.
   assign in_ready   = (int'(r_count) <= DEPTH - IN_WIDTH) && !redirect;
   assign w_enq_mask = in_ready ? in_en : '0;
   assign count      = r_count;

   always_comb begin
      out_en      = '0;
      out_data    = '0;
      out_rob_idx = '0;
      for (int i = 0; i < OUT_WIDTH; i++) begin
         out_en[i] = (i < int'(r_count)) && !issue_full && !redirect;
         out_data[i*DATA_WIDTH +: DATA_WIDTH] = r_data[slot(r_head[PTR_W-1:0], i)];
         out_rob_idx[i*ROB_WIDTH +: ROB_WIDTH] = r_rob[slot(r_head[PTR_W-1:0], i)];
      end
   end

   // Survivors of a redirect are the valid entries not younger than
   // redirect_idx. Program order makes the killed entries a suffix, so the
   // survivor count alone locates the new tail.
   always_comb begin
      w_alive = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_alive[i] = (i < int'(r_count)) &&
                      !LoopCompare(r_rob[slot(r_head[PTR_W-1:0], i)], redirect_idx);
      end
   end

   dq_popcount #(.WIDTH(IN_WIDTH),  .CNT_W(ENQ_W)) u_enq_cnt (
      .i_vec (w_enq_mask),
      .o_cnt (w_enq_cnt)
   );

   dq_popcount #(.WIDTH(OUT_WIDTH), .CNT_W(DEQ_W)) u_deq_cnt (
      .i_vec (out_en),
      .o_cnt (w_deq_cnt)
   );

   dq_popcount #(.WIDTH(DEPTH),     .CNT_W(CW)) u_alive_cnt (
      .i_vec (w_alive),
      .o_cnt (w_alive_cnt)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (redirect) begin
         r_tail  <= r_head + (PTR_W+1)'(w_alive_cnt);
         r_count <= w_alive_cnt;
      end else begin
         r_head  <= r_head + (PTR_W+1)'(w_deq_cnt);
         r_tail  <= r_tail + (PTR_W+1)'(w_enq_cnt);
         r_count <= r_count + CW'(w_enq_cnt) - CW'(w_deq_cnt);
      end
   end

   // NOTE: storage has no reset; entries are only read once count covers them.
   always_ff @(posedge clk) begin
      for (int i = 0; i < IN_WIDTH; i++) begin
         if (w_enq_mask[i]) begin
            r_data[slot(r_tail[PTR_W-1:0], i)] <= in_data[i*DATA_WIDTH +: DATA_WIDTH];
            r_rob[slot(r_tail[PTR_W-1:0], i)]  <= in_rob_idx[i*ROB_WIDTH +: ROB_WIDTH];
         end
      end
   end

endmodule

// File: tb/tb_int_dispatch_queue.sv
// -----------------------------------------------------------------------------
// tb_int_dispatch_queue
//   Self-checking bench for int_dispatch_queue. A queue-based model tracks the
//   in-order entry list; each scenario task compares DUT outputs against it or
//   against fixed expected values.
// -----------------------------------------------------------------------------
module tb_int_dispatch_queue;
   import int_dispatch_queue_pkg::*;

   localparam int DEPTH = 16;
   localparam int IW    = 4;
   localparam int OW    = ALU_SIZE;
   localparam int DW    = $bits(IntIssueBundle);
   localparam int RW    = ROB_WIDTH;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic               clk = 1'b0;
   logic               rst;
   logic [IW-1:0]      in_en;
   logic [IW*DW-1:0]   in_data;
   logic [IW*RW-1:0]   in_rob_idx;
   logic               in_ready;
   logic [OW-1:0]      out_en;
   logic [OW*DW-1:0]   out_data;
   logic [OW*RW-1:0]   out_rob_idx;
   logic               issue_full;
   logic               redirect;
   logic [RW-1:0]      redirect_idx;
   logic [CW-1:0]      count;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [RW-1:0] rob;
      logic [DW-1:0] data;
   } ent_t;

   ent_t          m_q[$];
   ent_t          slot_ent[IW];
   logic [RW-1:0] next_rob;

   always #5 clk = ~clk;

   int_dispatch_queue #(
      .DEPTH(DEPTH), .IN_WIDTH(IW), .OUT_WIDTH(OW), .DATA_WIDTH(DW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .in_en        (in_en),
      .in_data      (in_data),
      .in_rob_idx   (in_rob_idx),
      .in_ready     (in_ready),
      .out_en       (out_en),
      .out_data     (out_data),
      .out_rob_idx  (out_rob_idx),
      .issue_full   (issue_full),
      .redirect     (redirect),
      .redirect_idx (redirect_idx),
      .count        (count)
   );

   // ---------------- reference model ----------------
   // a is younger than b when it lies 1..half-ring steps ahead of b.
   function automatic bit m_younger(logic [RW-1:0] a, logic [RW-1:0] b);
      int d;
      d = (int'(a) - int'(b) + (1 << RW)) % (1 << RW);
      return (d >= 1) && (d < (1 << (RW - 1)));
   endfunction

   function automatic bit exp_ready();
      return (DEPTH - m_q.size() >= IW) && !redirect;
   endfunction

   function automatic logic [OW-1:0] exp_out_en();
      logic [OW-1:0] e;
      e = '0;
      for (int i = 0; i < OW; i++)
         e[i] = (i < m_q.size()) && !issue_full && !redirect;
      return e;
   endfunction

   // Present n new entries (slots 0..n-1) with consecutive ROB indices.
   task automatic set_enq(input int n);
      in_en = '0;
      for (int i = 0; i < IW; i++) begin
         slot_ent[i].rob  = next_rob + RW'(i);
         slot_ent[i].data = DW'($urandom);
         if (i < n) in_en[i] = 1'b1;
         in_data[i*DW +: DW]    = slot_ent[i].data;
         in_rob_idx[i*RW +: RW] = slot_ent[i].rob;
      end
   endtask

   // One clock edge: advance the model with the inputs that were applied,
   // then return at the following falling edge with enqueue/redirect cleared.
   task automatic tick();
      ent_t keep[$];
      bit   rdy;
      int   n_deq;
      int   n_enq;
      @(posedge clk);
      if (redirect) begin
         foreach (m_q[k])
            if (!m_younger(m_q[k].rob, redirect_idx)) keep.push_back(m_q[k]);
         m_q      = keep;
         next_rob = redirect_idx + RW'(1);
      end else begin
         rdy   = (DEPTH - m_q.size() >= IW);
         n_deq = issue_full ? 0 : ((m_q.size() < OW) ? m_q.size() : OW);
         repeat (n_deq) void'(m_q.pop_front());
         if (rdy) begin
            n_enq = 0;
            for (int i = 0; i < IW; i++)
               if (in_en[i]) begin
                  m_q.push_back(slot_ent[i]);
                  n_enq++;
               end
            next_rob = next_rob + RW'(n_enq);
         end
      end
      @(negedge clk);
      in_en    = '0;
      redirect = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b0; in_en = '0; in_data = '0; in_rob_idx = '0;
      issue_full = 1'b0; redirect = 1'b0; redirect_idx = '0;
      repeat (2) @(negedge clk);
      #1;
      total++; if (count !== '0)   begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
      total++; if (out_en !== '0)  begin bad++; $display("FAIL reset_out_en got=%b want=0", out_en); end
      total++; if (in_ready !== 1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
      @(negedge clk);
      rst = 1'b1;
      m_q.delete();
      next_rob = '0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      set_enq(4);
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL basic_ready got=%b want=1", in_ready); end
      tick();
      #1;
      total++; if (out_en !== 4'b1111) begin bad++; $display("FAIL basic_out_en got=%b want=1111", out_en); end
      for (int i = 0; i < OW; i++) begin
         total++;
         if (out_rob_idx[i*RW +: RW] !== RW'(i) || out_data[i*DW +: DW] !== m_q[i].data) begin
            bad++;
            $display("FAIL basic_slot%0d got rob=%0d data=%h want rob=%0d data=%h", i,
                     out_rob_idx[i*RW +: RW], out_data[i*DW +: DW], i, m_q[i].data);
         end
      end
      tick();
      #1;
      total++; if (count !== '0) begin bad++; $display("FAIL basic_drain_count got=%0d want=0", count); end
   endtask

   // Dequeue every remaining entry, checking the oldest slot each cycle.
   task automatic test_drain(input string tag);
      issue_full = 1'b0;
      for (int c = 0; c < 8 && m_q.size() > 0; c++) begin
         #1;
         total++;
         if (out_en !== exp_out_en() || out_rob_idx[RW-1:0] !== m_q[0].rob) begin
            bad++;
            $display("FAIL %s_drain got en=%b rob=%0d want en=%b rob=%0d", tag,
                     out_en, out_rob_idx[RW-1:0], exp_out_en(), m_q[0].rob);
         end
         tick();
      end
      #1;
      total++; if (count !== '0) begin bad++; $display("FAIL %s_drain_count got=%0d want=0", tag, count); end
   endtask

   task automatic test_fill();
      issue_full = 1'b1;
      for (int g = 0; g < 3; g++) begin
         set_enq(4);
         #1;
         total++;
         if (in_ready !== 1'b1 || out_en !== '0) begin
            bad++; $display("FAIL fill_group%0d got ready=%b en=%b want ready=1 en=0", g, in_ready, out_en);
         end
         tick();
      end
      #1;
      total++; if (count !== CW'(12)) begin bad++; $display("FAIL fill_count12 got=%0d want=12", count); end
      set_enq(1);
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL fill_ready_at12 got=%b want=1", in_ready); end
      tick();
      set_enq(4);
      #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL fill_ready_at13 got=%b want=0", in_ready); end
      total++; if (out_en !== '0)     begin bad++; $display("FAIL fill_out_en got=%b want=0", out_en); end
      tick();
      #1;
      total++; if (count !== CW'(13)) begin bad++; $display("FAIL fill_hold_count got=%0d want=13", count); end
      test_drain("fill");
   endtask

   task automatic test_redirect();
      next_rob   = RW'(5);
      issue_full = 1'b1;
      set_enq(4); tick();
      set_enq(4); tick();
      set_enq(2); tick();
      #1;
      total++; if (count !== CW'(10)) begin bad++; $display("FAIL redir_pre_count got=%0d want=10", count); end
      redirect = 1'b1; redirect_idx = RW'(9);
      #1;
      total++;
      if (out_en !== '0 || in_ready !== 1'b0) begin
         bad++; $display("FAIL redir_cycle got en=%b ready=%b want en=0 ready=0", out_en, in_ready);
      end
      tick();
      #1;
      total++; if (count !== CW'(5)) begin bad++; $display("FAIL redir_count got=%0d want=5", count); end
      issue_full = 1'b0;
      #1;
      for (int i = 0; i < OW; i++) begin
         total++;
         if (out_rob_idx[i*RW +: RW] !== RW'(5 + i)) begin
            bad++; $display("FAIL redir_slot%0d got=%0d want=%0d", i, out_rob_idx[i*RW +: RW], 5 + i);
         end
      end
      tick();
      #1;
      total++;
      if (out_en !== 4'b0001 || out_rob_idx[RW-1:0] !== RW'(9)) begin
         bad++; $display("FAIL redir_last got en=%b rob=%0d want en=0001 rob=9", out_en, out_rob_idx[RW-1:0]);
      end
      tick();
      #1;
      total++; if (count !== '0) begin bad++; $display("FAIL redir_empty got=%0d want=0", count); end
   endtask

   task automatic test_redirect_simul();
      issue_full = 1'b1;
      set_enq(4); tick();
      set_enq(4); tick();
      issue_full   = 1'b0;
      redirect_idx = m_q[2].rob;
      set_enq(4);
      redirect = 1'b1;
      #1;
      total++;
      if (out_en !== '0 || in_ready !== 1'b0) begin
         bad++; $display("FAIL simul_cycle got en=%b ready=%b want en=0 ready=0", out_en, in_ready);
      end
      tick();
      #1;
      total++; if (count !== CW'(3)) begin bad++; $display("FAIL simul_count got=%0d want=3", count); end
      test_drain("simul");
   endtask

   // Random traffic compared cycle by cycle against the model; with_redirect
   // adds occasional flushes at a queued ROB index.
   task automatic test_random(input string tag, input int cycles, input bit with_redirect);
      int n;
      for (int c = 0; c < cycles; c++) begin
         n = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : 4;
         set_enq(n);
         issue_full = ($urandom_range(0, 3) == 0);
         if (with_redirect && m_q.size() > 0 && $urandom_range(0, 7) == 0) begin
            redirect     = 1'b1;
            redirect_idx = m_q[$urandom_range(0, m_q.size() - 1)].rob;
         end
         #1;
         total++;
         if (in_ready !== exp_ready() || out_en !== exp_out_en() ||
             count !== CW'(m_q.size()) || int'(count) > DEPTH) begin
            bad++;
            $display("FAIL %s_ctl c=%0d got ready=%b en=%b count=%0d want ready=%b en=%b count=%0d",
                     tag, c, in_ready, out_en, count, exp_ready(), exp_out_en(), m_q.size());
         end
         for (int i = 0; i < OW; i++) begin
            if (exp_out_en()[i]) begin
               total++;
               if (out_rob_idx[i*RW +: RW] !== m_q[i].rob || out_data[i*DW +: DW] !== m_q[i].data) begin
                  bad++;
                  $display("FAIL %s_slot c=%0d i=%0d got rob=%0d data=%h want rob=%0d data=%h", tag, c, i,
                           out_rob_idx[i*RW +: RW], out_data[i*DW +: DW], m_q[i].rob, m_q[i].data);
               end
            end
         end
         tick();
      end
      test_drain(tag);
   endtask

   task automatic test_async_reset();
      issue_full = 1'b1;
      set_enq(4); tick();
      set_enq(3); tick();
      #1;
      total++; if (count !== CW'(7)) begin bad++; $display("FAIL areset_pre_count got=%0d want=7", count); end
      issue_full = 1'b0;
      #1;
      rst = 1'b0;
      #1;
      total++; if (count !== '0)  begin bad++; $display("FAIL areset_count got=%0d want=0", count); end
      total++; if (out_en !== '0) begin bad++; $display("FAIL areset_out_en got=%b want=0", out_en); end
      m_q.delete();
      @(negedge clk);
      rst      = 1'b1;
      next_rob = '0;
      set_enq(2);
      tick();
      #1;
      total++;
      if (out_en !== 4'b0011 || out_rob_idx[RW-1:0] !== RW'(0) || out_rob_idx[RW +: RW] !== RW'(1)) begin
         bad++; $display("FAIL areset_refill got en=%b rob0=%0d rob1=%0d want en=0011 rob0=0 rob1=1",
                         out_en, out_rob_idx[RW-1:0], out_rob_idx[RW +: RW]);
      end
      tick();
      #1;
      total++; if (count !== '0) begin bad++; $display("FAIL areset_final got=%0d want=0", count); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_fill();
      test_redirect();
      test_redirect_simul();
      test_random("wrap", 40, 1'b0);
      test_random("rand_redir", 60, 1'b1);
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running want=finished");
      $fatal(1, "bench timeout");
   end

endmodule
